cluster_priority_encoder: RTL and testbench

Consumes the truncated s-bit vector and pass counter from the cluster truncation stage at 160 MHz and priority-encodes the least-significant set bit on every clock. The encoder is a 3-stage pipeline. Per-pass results are collected into an 8-slot cluster bank, which is presented once per 20 MHz frame with a count, a valid mask and an overflow flag. The block sits directly downstream of the truncator and upstream of the cluster packer/formatter.

---
 rtl/cluster_priority_encoder.sv | 169 ++++++++++++++++
 tb/tb_cluster_priority_encoder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cluster_priority_encoder.sv
// cluster_priority_encoder: 3-stage lowest-set-bit encoder for the truncated s-bit vector,
// collecting one address per pass into an 8-slot bank presented once per frame.
module cluster_priority_encoder #(
   parameter int MXVPF  = 768,
   parameter int MXSEGS = 16,
   parameter int ADRB   = 10,
   parameter int MXCLST = 8,
   localparam int SEGSIZE = MXVPF / MXSEGS,
   localparam int LW = $clog2(SEGSIZE),
   localparam int SW = $clog2(MXSEGS),
   localparam int PW = $clog2(MXCLST),
   localparam int CW = $clog2(MXCLST + 1)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [PW-1:0]          pass_in,
   input  logic [MXVPF-1:0]       vpfs_in,
   output logic [ADRB-1:0]        adr_stream,
   output logic                   vld_stream,
   output logic [MXCLST*ADRB-1:0] adr_out,
   output logic [MXCLST-1:0]      vld_out,
   output logic [CW-1:0]          cnt_out,
   output logic                   overflow_out,
   output logic                   frame_valid
);

   function automatic logic [LW-1:0] low_idx(input logic [SEGSIZE-1:0] s);
      low_idx = '0;
      for (int i = SEGSIZE - 1; i >= 0; i--)
         if (s[i]) low_idx = LW'(i);
   endfunction

   // segment base address as a shift-add over the set bits of SEGSIZE
   function automatic logic [ADRB-1:0] seg_base(input logic [SW-1:0] s);
      seg_base = '0;
      for (int b = 0; b <= LW; b++)
         if (SEGSIZE[b]) seg_base = seg_base + (ADRB'(s) << b);
   endfunction

   logic [MXSEGS-1:0]         act_c, multi_c;
   logic [MXSEGS-1:0][LW-1:0] loc_c;

   for (genvar g = 0; g < MXSEGS; g++) begin : g_seg
      logic [SEGSIZE-1:0] seg;
      assign seg        = vpfs_in[g*SEGSIZE +: SEGSIZE];
      assign act_c[g]   = |seg;
      assign multi_c[g] = |(seg & (seg - SEGSIZE'(1)));
      assign loc_c[g]   = low_idx(seg);
   end

   logic [MXSEGS-1:0]         s1_act, s1_multi;
   logic [MXSEGS-1:0][LW-1:0] s1_loc;
   logic [PW-1:0]             s1_pass;

   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         s1_act   <= '0;
         s1_multi <= '0;
         s1_loc   <= '0;
         s1_pass  <= '0;
      end else begin
         s1_act   <= act_c;
         s1_multi <= multi_c;
         s1_loc   <= loc_c;
         s1_pass  <= pass_in;
      end

   logic [SW-1:0] sel_seg;
   logic [LW-1:0] sel_loc;
   logic          any_c, ovf_c;

   always_comb begin
      sel_seg = '0;
      sel_loc = '0;
      for (int i = MXSEGS - 1; i >= 0; i--)
         if (s1_act[i]) begin
            sel_seg = SW'(i);
            sel_loc = s1_loc[i];
         end
      any_c = |s1_act;
      ovf_c = (|s1_multi) | (|(s1_act & (s1_act - MXSEGS'(1))));
   end

   logic [SW-1:0] s2_seg;
   logic [LW-1:0] s2_loc;
   logic          s2_any, s2_ovf;
   logic [PW-1:0] s2_pass;

   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         s2_seg  <= '0;
         s2_loc  <= '0;
         s2_any  <= 1'b0;
         s2_ovf  <= 1'b0;
         s2_pass <= '0;
      end else begin
         s2_seg  <= sel_seg;
         s2_loc  <= sel_loc;
         s2_any  <= any_c;
         s2_ovf  <= ovf_c;
         s2_pass <= s1_pass;
      end

   logic [ADRB-1:0] adr_c;
   logic [PW-1:0]   pass_d3;
   logic            ovf_d3;

   assign adr_c = s2_any ? seg_base(s2_seg) + ADRB'(s2_loc) : '1;

   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         adr_stream <= '1;
         vld_stream <= 1'b0;
         pass_d3    <= '0;
         ovf_d3     <= 1'b0;
      end else begin
         adr_stream <= adr_c;
         vld_stream <= s2_any;
         pass_d3    <= s2_pass;
         ovf_d3     <= s2_ovf;
      end

   logic [MXCLST-1:0][ADRB-1:0] w_adr, nb_adr;
   logic [MXCLST-1:0]           w_vld, nb_vld;
   logic                        last;

   assign last = pass_d3 == PW'(MXCLST - 1);

   // pass 0 opens a frame, so any slots left over from an aborted frame are wiped here
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         w_adr <= '1;
         w_vld <= '0;
      end else begin
         for (int k = 0; k < MXCLST; k++)
            if (PW'(k) == pass_d3) begin
               w_adr[k] <= adr_stream;
               w_vld[k] <= vld_stream;
            end else if (pass_d3 == '0) begin
               w_adr[k] <= '1;
               w_vld[k] <= 1'b0;
            end
      end

   always_comb begin
      nb_adr = w_adr;
      nb_vld = w_vld;
      nb_adr[MXCLST-1] = adr_stream;
      nb_vld[MXCLST-1] = vld_stream;
   end

   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         adr_out      <= '1;
         vld_out      <= '0;
         cnt_out      <= '0;
         overflow_out <= 1'b0;
         frame_valid  <= 1'b0;
      end else begin
         frame_valid <= last;
         if (last) begin
            adr_out      <= nb_adr;
            vld_out      <= nb_vld;
            cnt_out      <= CW'($countones(nb_vld));
            overflow_out <= ovf_d3;
         end
      end

endmodule

// File: tb/tb_cluster_priority_encoder.sv
// tb_cluster_priority_encoder: directed table and frame sequences for cluster_priority_encoder.
module tb_cluster_priority_encoder;

   localparam logic [9:0] E = 10'h3FF;

   typedef struct {
      logic [2:0]   pass;
      logic [767:0] vpfs;
      logic [9:0]   adr;
      logic         vld;
   } vec_t;

   typedef logic [9:0] slots_t [8];

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic [2:0]   pass_in = '0;
   logic [767:0] vpfs_in = '0;
   logic [9:0]   adr_stream;
   logic         vld_stream;
   logic [79:0]  adr_out;
   logic [7:0]   vld_out;
   logic [3:0]   cnt_out;
   logic         overflow_out;
   logic         frame_valid;

   int checks = 0;
   int errors = 0;
   int fv_cnt = 0;

   cluster_priority_encoder dut (
      .clock(clock),
      .reset(reset),
      .pass_in(pass_in),
      .vpfs_in(vpfs_in),
      .adr_stream(adr_stream),
      .vld_stream(vld_stream),
      .adr_out(adr_out),
      .vld_out(vld_out),
      .cnt_out(cnt_out),
      .overflow_out(overflow_out),
      .frame_valid(frame_valid)
   );

   always #5 clock = ~clock;

   always @(posedge clock) if (frame_valid) fv_cnt <= fv_cnt + 1;

   function automatic logic [767:0] oh(input int b);
      oh = '0;
      oh[b] = 1'b1;
   endfunction

   function automatic logic [79:0] pk(input slots_t s);
      pk = '0;
      for (int k = 0; k < 8; k++) pk[k*10 +: 10] = s[k];
   endfunction

   task automatic chk(input string n, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   task automatic step(input logic [2:0] p, input logic [767:0] v);
      pass_in = p;
      vpfs_in = v;
      @(negedge clock);
   endtask

   task automatic trunc_frame(input logic [767:0] v);
      logic [767:0] cur;
      cur = v;
      for (int p = 0; p < 8; p++) begin
         step(3'(p), cur);
         cur = cur & (cur - 768'd1);
      end
   endtask

   task automatic frame_chk(input string n, input int f0, input logic [79:0] ea,
                            input logic [7:0] ev, input logic [3:0] ec, input logic eo);
      int lat;
      lat = -1;
      for (int c = 1; c <= 8 && lat < 0; c++) begin
         step(3'd0, '0);
         if (frame_valid) lat = c;
      end
      chk({n, " latency"}, 80'(lat), 80'd3);
      chk({n, " adr_out"}, adr_out, ea);
      chk({n, " vld_out"}, 80'(vld_out), 80'(ev));
      chk({n, " cnt_out"}, 80'(cnt_out), 80'(ec));
      chk({n, " overflow_out"}, 80'(overflow_out), 80'(eo));
      repeat (4) step(3'd0, '0);
      chk({n, " frame_valid count"}, 80'(fv_cnt - f0), 80'd1);
   endtask

   task automatic reset_chk(input string n);
      chk({n, " adr_stream"}, 80'(adr_stream), 80'(E));
      chk({n, " vld_stream"}, 80'(vld_stream), 80'd0);
      chk({n, " adr_out"}, adr_out, {80{1'b1}});
      chk({n, " vld_out"}, 80'(vld_out), 80'd0);
      chk({n, " cnt_out"}, 80'(cnt_out), 80'd0);
      chk({n, " overflow_out"}, 80'(overflow_out), 80'd0);
      chk({n, " frame_valid"}, 80'(frame_valid), 80'd0);
   endtask

   initial begin
      vec_t         tbl [10];
      slots_t       sl;
      logic [767:0] v;
      int           f0;

      tbl[0] = '{3'd0, oh(0), 10'd0, 1'b1};
      tbl[1] = '{3'd0, oh(47), 10'd47, 1'b1};
      tbl[2] = '{3'd0, oh(48), 10'd48, 1'b1};
      tbl[3] = '{3'd0, oh(767), 10'd767, 1'b1};
      tbl[4] = '{3'd0, 768'd0, E, 1'b0};
      tbl[5] = '{3'd0, oh(100) | oh(200), 10'd100, 1'b1};
      tbl[6] = '{3'd0, oh(95) | oh(96), 10'd95, 1'b1};
      tbl[7] = '{3'd0, {768{1'b1}}, 10'd0, 1'b1};
      tbl[8] = '{3'd0, oh(720), 10'd720, 1'b1};
      tbl[9] = '{3'd0, oh(383) | oh(700), 10'd383, 1'b1};

      #1 reset = 1'b1;
      #1 reset_chk("reset");
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      for (int j = 0; j < 13; j++) begin
         if (j >= 3) begin
            chk($sformatf("stream%0d adr", j - 3), 80'(adr_stream), 80'(tbl[j-3].adr));
            chk($sformatf("stream%0d vld", j - 3), 80'(vld_stream), 80'(tbl[j-3].vld));
         end
         if (j < 10) step(tbl[j].pass, tbl[j].vpfs);
         else step(3'd0, '0);
      end

      f0 = fv_cnt;
      step(3'd0, oh(100));
      step(3'd1, '0);
      step(3'd2, '0);
      chk("single adr_stream", 80'(adr_stream), 80'd100);
      chk("single vld_stream", 80'(vld_stream), 80'd1);
      for (int p = 3; p < 8; p++) step(3'(p), '0);
      sl = '{10'd100, E, E, E, E, E, E, E};
      frame_chk("single", f0, pk(sl), 8'h01, 4'd1, 1'b0);

      f0 = fv_cnt;
      trunc_frame(oh(47) | oh(48) | oh(767));
      sl = '{10'd47, 10'd48, 10'd767, E, E, E, E, E};
      frame_chk("boundary", f0, pk(sl), 8'h07, 4'd3, 1'b0);

      v = oh(5) | oh(100) | oh(200) | oh(300) | oh(400) | oh(500) | oh(600) | oh(700);
      sl = '{10'd5, 10'd100, 10'd200, 10'd300, 10'd400, 10'd500, 10'd600, 10'd700};
      f0 = fv_cnt;
      trunc_frame(v | oh(767));
      frame_chk("full ovf", f0, pk(sl), 8'hFF, 4'd8, 1'b1);

      f0 = fv_cnt;
      for (int p = 0; p < 7; p++) step(3'(p), oh(100 + 50 * p));
      step(3'd7, oh(0) | oh(1));
      frame_chk("multi ovf", f0, pk('{10'd100, 10'd150, 10'd200, 10'd250, 10'd300,
                                      10'd350, 10'd400, 10'd0}), 8'hFF, 4'd8, 1'b1);

      f0 = fv_cnt;
      trunc_frame(v);
      frame_chk("full", f0, pk(sl), 8'hFF, 4'd8, 1'b0);

      f0 = fv_cnt;
      trunc_frame('0);
      sl = '{E, E, E, E, E, E, E, E};
      frame_chk("empty", f0, pk(sl), 8'h00, 4'd0, 1'b0);

      trunc_frame(v);
      repeat (5) step(3'd0, '0);
      f0 = fv_cnt;
      for (int p = 0; p < 5; p++) step(3'(p), oh(10 * (p + 1)));
      #2 reset = 1'b1;
      pass_in = '0;
      vpfs_in = '0;
      #1 reset_chk("midreset");
      @(negedge clock);
      reset = 1'b0;
      repeat (12) step(3'd0, '0);
      chk("midreset frame_valid count", 80'(fv_cnt - f0), 80'd0);
      chk("midreset vld_out hold", 80'(vld_out), 80'd0);

      f0 = fv_cnt;
      for (int p = 0; p < 4; p++) step(3'(p), oh(10 * (p + 1)));
      trunc_frame(oh(11) | oh(22) | oh(33));
      sl = '{10'd11, 10'd22, 10'd33, E, E, E, E, E};
      frame_chk("restart", f0, pk(sl), 8'h07, 4'd3, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
